// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: bus widths, default address map
// and decoder FSM state type.
package axil_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    localparam int DEF_SLAVE_NUM = 4;
    localparam int ERR_IDX       = DEF_SLAVE_NUM;

    // Index 0 is the rightmost element of each concatenation.
    localparam logic [DEF_SLAVE_NUM-1:0][AXI_ADDR_WIDTH-1:0] DEF_SLAVE_BASE = {
        32'h3000_0000,
        32'h2000_0000,
        32'h1000_0000,
        32'h0000_0000
    };

    localparam logic [DEF_SLAVE_NUM-1:0][AXI_ADDR_WIDTH-1:0] DEF_SLAVE_MASK = {
        32'hF000_0000,
        32'hF000_0000,
        32'hF000_0000,
        32'hF000_0000
    };

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        FWD,
        DATA
    } state_type_dec;

endpackage

// File: rtl/axil_addr_decode.sv
// Address-to-port decoder shared by the read and write routers.
// Lowest matching slave wins; no match selects the error port.
module axil_addr_decode
    import axil_pkg::*;
#(
    parameter int SLAVE_NUM = DEF_SLAVE_NUM,
    parameter logic [SLAVE_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [SLAVE_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_MASK = DEF_SLAVE_MASK
) (
    input  logic [AXI_ADDR_WIDTH-1:0]          addr,
    output logic [$clog2(SLAVE_NUM+1)-1:0]     sel
);

    localparam int SW = $clog2(SLAVE_NUM + 1);

    // Scan from the top so the lowest index is written last.
    always_comb begin
        sel = SW'(SLAVE_NUM);
        for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
                sel = SW'(i);
            end
        end
    end

endmodule

// File: rtl/axil_decoder_rd.sv
// AXI-Lite read router: one master, SLAVE_NUM slaves plus an
// error port, one outstanding transaction at a time.
module axil_decoder_rd
    import axil_pkg::*;
#(
    parameter int SLAVE_NUM = DEF_SLAVE_NUM,
    parameter logic [SLAVE_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [SLAVE_NUM-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_MASK = DEF_SLAVE_MASK
) (
    input  logic                                     aclk,
    input  logic                                     aresetn,

    input  logic [AXI_ADDR_WIDTH-1:0]                s_axil_araddr,
    input  logic                                     s_axil_arvalid,
    output logic                                     s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]                s_axil_rdata,
    output logic [1:0]                               s_axil_rresp,
    output logic                                     s_axil_rvalid,
    input  logic                                     s_axil_rready,

    output logic [SLAVE_NUM-1:0][AXI_ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [SLAVE_NUM-1:0]                     m_axil_arvalid,
    input  logic [SLAVE_NUM-1:0]                     m_axil_arready,
    input  logic [SLAVE_NUM-1:0][AXI_DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [SLAVE_NUM-1:0][1:0]                m_axil_rresp,
    input  logic [SLAVE_NUM-1:0]                     m_axil_rvalid,
    output logic [SLAVE_NUM-1:0]                     m_axil_rready,

    output logic [AXI_ADDR_WIDTH-1:0]                e_axil_araddr,
    output logic                                     e_axil_arvalid,
    input  logic                                     e_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0]                e_axil_rdata,
    input  logic [1:0]                               e_axil_rresp,
    input  logic                                     e_axil_rvalid,
    output logic                                     e_axil_rready
);

    localparam int NP = SLAVE_NUM + 1;
    localparam int SW = $clog2(SLAVE_NUM + 1);

    state_type_dec state_q, state_d;

    logic [AXI_ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic [SW-1:0]                      sel_q, sel_d;
    logic [SW-1:0]                      dec_sel;
    logic                               arready_q, arready_d;
    logic [NP-1:0]                      arvalid_q, arvalid_d;
    logic [NP-1:0][AXI_ADDR_WIDTH-1:0]  araddr_q, araddr_d;

    // Error port is folded in as the highest index.
    logic [NP-1:0]                      arready_all;
    logic [NP-1:0]                      rvalid_all;
    logic [NP-1:0]                      rready_all;
    logic [NP-1:0][AXI_DATA_WIDTH-1:0]  rdata_all;
    logic [NP-1:0][1:0]                 rresp_all;

    assign arready_all = {e_axil_arready, m_axil_arready};
    assign rvalid_all  = {e_axil_rvalid,  m_axil_rvalid};
    assign rdata_all   = {e_axil_rdata,   m_axil_rdata};
    assign rresp_all   = {e_axil_rresp,   m_axil_rresp};

    axil_addr_decode #(
        .SLAVE_NUM  (SLAVE_NUM),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .addr (s_axil_araddr),
        .sel  (dec_sel)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            arready_q <= 1'b0;
            arvalid_q <= '0;
            araddr_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            arready_q <= arready_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        arready_d = arready_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        unique case (state_q)
            IDLE: begin
                if (s_axil_arvalid) begin
                    addr_d    = s_axil_araddr;
                    sel_d     = dec_sel;
                    arready_d = 1'b1;
                    state_d   = ACCEPT;
                end
            end
            ACCEPT: begin
                arready_d        = 1'b0;
                arvalid_d[sel_q] = 1'b1;
                araddr_d[sel_q]  = addr_q;
                state_d          = FWD;
            end
            FWD: begin
                if (arready_all[sel_q]) begin
                    arvalid_d[sel_q] = 1'b0;
                    state_d          = DATA;
                end
            end
            DATA: begin
                if (rvalid_all[sel_q] && s_axil_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // R path is live only in DATA so stray slave responses are dropped.
    always_comb begin
        s_axil_rvalid = 1'b0;
        s_axil_rdata  = '0;
        s_axil_rresp  = 2'b00;
        rready_all    = '0;
        if (state_q == DATA) begin
            s_axil_rvalid     = rvalid_all[sel_q];
            s_axil_rdata      = rdata_all[sel_q];
            s_axil_rresp      = rresp_all[sel_q];
            rready_all[sel_q] = s_axil_rready;
        end
    end

    assign s_axil_arready = arready_q;
    assign m_axil_arvalid = arvalid_q[SLAVE_NUM-1:0];
    assign m_axil_araddr  = araddr_q[SLAVE_NUM-1:0];
    assign m_axil_rready  = rready_all[SLAVE_NUM-1:0];
    assign e_axil_arvalid = arvalid_q[SLAVE_NUM];
    assign e_axil_araddr  = araddr_q[SLAVE_NUM];
    assign e_axil_rready  = rready_all[SLAVE_NUM];

endmodule

// File: doc/axil_decoder_rd.md
Name: axil_decoder_rd

Overview:
- Read-side address decoder/router between one AXI-Lite read master and SLAVE_NUM read slaves.
- Also serves the invalid-address read responder, attached as the error port.
- Accepts one AR transaction at a time, decodes araddr against per-slave base/mask, and forwards AR to the selected port (slave or error).
- Returns that port's R channel to the master; the selection is held until the R handshake completes.

Parameters:
- SLAVE_NUM, 4, number of decoded slave ports.
- SLAVE_BASE, {32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000}, per-slave base address, AXI_ADDR_WIDTH each.
- SLAVE_MASK, all 32'hF000_0000, per-slave compare mask; slave i matches when (araddr & SLAVE_MASK[i]) == SLAVE_BASE[i].

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- s_axil_araddr  in  AXI_ADDR_WIDTH  master read address
- s_axil_arvalid  in  1  master AR valid
- s_axil_arready  out  1  master AR ready
- s_axil_rdata  out  AXI_DATA_WIDTH  read data to master
- s_axil_rresp  out  2  read response to master
- s_axil_rvalid  out  1  R valid to master
- s_axil_rready  in  1  R ready from master
- m_axil_araddr  out  [SLAVE_NUM][AXI_ADDR_WIDTH]  per-slave address
- m_axil_arvalid  out  SLAVE_NUM  per-slave AR valid
- m_axil_arready  in  SLAVE_NUM  per-slave AR ready
- m_axil_rdata  in  [SLAVE_NUM][AXI_DATA_WIDTH]  per-slave read data
- m_axil_rresp  in  [SLAVE_NUM][2]  per-slave response
- m_axil_rvalid  in  SLAVE_NUM  per-slave R valid
- m_axil_rready  out  SLAVE_NUM  per-slave R ready
- e_axil_araddr/arvalid/arready/rdata/rresp/rvalid/rready  same directions and widths as one m_ port  error port to the invalid-address responder

Behaviour:
- Clock and reset: aclk; reset aresetn, synchronous, active-low.
- Reset values: state=IDLE; s_axil_arready=0; all m_/e_ arvalid=0; all m_/e_ araddr=0; sel=0; addr register=0.
- Reset mid-transaction aborts the transaction; no replay.
- Port indexing: ports 0..SLAVE_NUM-1 are the slaves; index SLAVE_NUM denotes the error port.
- State IDLE: on arvalid=1, latch araddr into addr_q and latch sel (lowest matching index, else SLAVE_NUM); set s_axil_arready<=1; go to ACCEPT.
- State ACCEPT: the master handshake completes on this cycle. Set s_axil_arready<=0, arvalid[sel]<=1, araddr[sel]<=addr_q; go to FWD.
- State FWD: hold arvalid[sel] until arready[sel]=1. On that edge, arvalid[sel]<=0; go to DATA.
- State DATA: R channel is a combinational mux from port sel:
  - s_axil_rdata/rresp/rvalid = port sel values; rready[sel]=s_axil_rready.
  - On rvalid&rready, go to IDLE.
- Outside DATA: s_axil_rvalid=0, s_axil_rdata='0, s_axil_rresp=2'b00; every m_/e_ rready=0.
- Unselected ports: arvalid=0 and rready=0 at all times. rvalid from an unselected port is ignored and never reaches the master.
- Minimum latency: arvalid to downstream arvalid is 2 cycles. With a zero-wait slave, end-to-end is AR accept, forward, R in DATA.
- Throughput: one outstanding transaction; back-to-back needs at least 4 cycles per transaction.
- Overlapping regions: the lowest index wins.
- Error port: decoded like a slave, no special-casing. The responder on it returns rresp=2'b11, rdata=all-ones, passed through unchanged.

Decomposition:
- axil_pkg gains:
  - SLAVE_NUM default and SLAVE_BASE/SLAVE_MASK default arrays.
  - Typedef state_type_dec {IDLE, ACCEPT, FWD, DATA} (logic [1:0]).
  - Localparam ERR_IDX = SLAVE_NUM.
- Sub-module axil_addr_decode (combinational): araddr -> sel index [$clog2(SLAVE_NUM+1)-1:0]. It is reused by the write-side decoder.

Test Plan:
- araddr=0x1000_0040, slave1 arready after 3 cycles, rdata=0xCAFE_F00D, rresp=00 -> master sees arready 1 cycle after arvalid; m_arvalid[1] 2 cycles after arvalid, held 3 cycles; master receives 0xCAFE_F00D/00; other ports idle.
- araddr=0x5000_0000 with the invalid responder on the e_ port -> e_arvalid asserted; master gets rresp=11, rdata=0xFFFF_FFFF; no m_arvalid activity.
- Master rready held low 5 cycles in DATA -> s_axil_rvalid/rdata stable; m_rready[sel] low; return to IDLE one cycle after rready rises.
- Slave2 asserts rvalid spuriously while slave0 is being read -> s_axil_rvalid reflects slave0 only; m_rready[2]=0.
- aresetn low during FWD -> next cycle all arvalid/arready/rvalid outputs 0 and state IDLE; a new request to 0x3000_0000 completes normally.
- Back-to-back reads 0x0, 0x2000_0004, 0x9000_0000 with zero-wait slaves -> three correct responses in order, 4 cycles apart.
